// File: rtl/imem_boot_loader_if.sv
// Byte-stream receive and instruction-memory write bus of the boot loader.
// The slave modport is the loader; the master modport is the stream source / memory side.
interface imem_boot_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_adr;
  logic [31:0] imem_wdata;

  modport slave  (input  rx_data, rx_valid,
                  output rx_ready, imem_we, imem_adr, imem_wdata);
  modport master (output rx_data, rx_valid,
                  input  rx_ready, imem_we, imem_adr, imem_wdata);
endinterface

// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader: takes a length-prefixed little-endian byte stream,
// writes consecutive 32-bit words and keeps the MIPS core in reset until loading completes.
module imem_boot_loader #(
  parameter logic [31:0] BASE_ADR  = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024,
  parameter int          TIMEOUT   = 1000
) (
  input  logic               clk,
  input  logic               rst,
  imem_boot_loader_if.slave  bus,
  input  logic               reload,
  output logic               core_rst,
  output logic               done,
  output logic               err
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {HDR0, HDR1, DATA, DONE, ERR} state_t;
  state_t state, state_n;

  logic          rx_ready_q, imem_we_q;
  logic [31:0]   imem_adr_q, imem_wdata_q;
  logic          ready_n, done_n, err_n, core_rst_n;
  logic [7:0]    n_lo;
  logic [15:0]   n_words, w_idx;
  logic [1:0]    b_cnt;
  logic [23:0]   asm_q;
  logic          fin_q;
  logic [TW-1:0] tmo_cnt;

  logic        xfer, tmo_hit, restart, data_xfer, in_wait, stay_wait;
  logic [15:0] hdr_n;

  assign xfer      = bus.rx_valid & rx_ready_q;
  assign hdr_n     = {bus.rx_data, n_lo};
  assign tmo_hit   = !bus.rx_valid && (tmo_cnt == TW'(TIMEOUT - 1));
  assign restart   = ((state == DONE) || (state == ERR)) && reload;
  // a byte arriving in the final word's strobe cycle is dropped
  assign data_xfer = (state == DATA) && xfer && !fin_q;
  assign in_wait   = (state == HDR1) || (state == DATA);
  assign stay_wait = (state_n == HDR1) || (state_n == DATA);

  assign bus.rx_ready   = rx_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_adr   = imem_adr_q;
  assign bus.imem_wdata = imem_wdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= HDR0;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      HDR0: if (xfer) state_n = HDR1;
      HDR1: begin
        if (xfer) begin
          if (hdr_n == 16'd0)                        state_n = DONE;
          else if ({16'd0, hdr_n} > 32'(MAX_WORDS))  state_n = ERR;
          else                                       state_n = DATA;
        end else if (tmo_hit) state_n = ERR;
      end
      DATA: begin
        if (fin_q)        state_n = DONE;
        else if (tmo_hit) state_n = ERR;
      end
      DONE, ERR: if (reload) state_n = HDR0;
      default: state_n = ERR;
    endcase
  end

  // status outputs are registered off the next state so they move on state entry
  always_comb begin
    ready_n    = (state_n == HDR0) || (state_n == HDR1) || (state_n == DATA);
    done_n     = (state_n == DONE);
    err_n      = (state_n == ERR);
    core_rst_n = (state_n != DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_ready_q <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      core_rst   <= 1'b1;
    end else begin
      rx_ready_q <= ready_n;
      done       <= done_n;
      err        <= err_n;
      core_rst   <= core_rst_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      imem_we_q    <= 1'b0;
      imem_adr_q   <= BASE_ADR;
      imem_wdata_q <= 32'd0;
      n_lo         <= 8'd0;
      n_words      <= 16'd0;
      w_idx        <= 16'd0;
      b_cnt        <= 2'd0;
      asm_q        <= 24'd0;
      fin_q        <= 1'b0;
      tmo_cnt      <= '0;
    end else if (restart) begin
      imem_we_q  <= 1'b0;
      imem_adr_q <= BASE_ADR;
      w_idx      <= 16'd0;
      b_cnt      <= 2'd0;
      fin_q      <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      imem_we_q <= 1'b0;
      fin_q     <= 1'b0;
      if (imem_we_q) imem_adr_q <= imem_adr_q + 32'd4;
      if ((state == HDR0) && xfer) n_lo    <= bus.rx_data;
      if ((state == HDR1) && xfer) n_words <= hdr_n;
      if (data_xfer) begin
        b_cnt <= b_cnt + 2'd1;
        if (b_cnt == 2'd3) begin
          imem_we_q    <= 1'b1;
          imem_wdata_q <= {bus.rx_data, asm_q};
          w_idx        <= w_idx + 16'd1;
          fin_q        <= ((w_idx + 16'd1) == n_words);
        end else begin
          asm_q <= {bus.rx_data, asm_q[23:8]};
        end
      end
      if (in_wait && stay_wait && !xfer) tmo_cnt <= tmo_cnt + TW'(1);
      else                               tmo_cnt <= '0;
    end
  end
endmodule
